mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 14, word address width; DATA_W, default 32, data width; STARVE_MAX, default 4, consecutive instruction-fetch losses before a forced fetch grant.
REQ-002 Ports SHALL be, as name direction width meaning:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch granted/issued
- if_valid  out  1  fetch data valid pulse
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  data granted/issued
- d_valid  out  1  data completion pulse (read or write)
- d_rdata  out  DATA_W  read data
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, 1-cycle synchronous
- busy  out  1  FSM not in IDLE

Function
REQ-003 The block SHALL share one single-port synchronous memory between the fetch and data requesters.
REQ-004 FSM states SHALL be IDLE, ISSUE, RESP.
- IDLE -> ISSUE when any request is present.
- ISSUE -> RESP unconditionally.
- RESP -> ISSUE if a request is present, else IDLE.
REQ-005 The winner SHALL be latched at the edge entering ISSUE, together with its address, we and wdata.
REQ-006 In ISSUE, mem_en SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL reflect the latched request; the winner's gnt SHALL be high for exactly this one cycle.
REQ-007 In RESP, the winner's valid SHALL be high for exactly one cycle, and rdata SHALL equal mem_rdata for reads.
REQ-008 Timing SHALL be: request sampled at edge N; gnt and mem_en in cycle N+1; valid in cycle N+2. Sustained throughput SHALL be one access per 2 cycles.
REQ-009 d_rdata and if_rdata SHALL be registered, update only on their own read completions, and hold between completions; d_rdata SHALL NOT change on a write.
REQ-010 Arbitration SHALL give data priority over fetch when both requests are present at the same sampling edge.
REQ-011 Outside ISSUE, mem_en and mem_we SHALL be 0; mem_addr and mem_wdata SHALL hold their last values.
REQ-012 Requester rules SHALL be: a requester holds req, addr and data stable until its gnt; a request deasserted before gnt is a protocol violation with undefined result.
REQ-013 At no time SHALL more than one gnt or more than one valid be high.

Reset
REQ-014 Reset SHALL be asynchronous, active-low (rst = 0), and force:
- FSM to IDLE
- all gnt, valid, mem_en, mem_we and busy to 0
- all rdata, mem_addr and mem_wdata to 0
- starvation counter to 0
REQ-015 Reset asserted during ISSUE or RESP SHALL drop the in-flight access with no valid pulse; after release, arbitration SHALL restart from IDLE.

Configuration
REQ-016 Macro ARB_STARVE_GUARD_EN, when defined, SHALL add a counter of consecutive fetch losses, where a loss is if_req high while data wins. When the counter reaches STARVE_MAX, the next arbitration SHALL grant fetch regardless of d_req and clear the counter. Any fetch grant SHALL also clear the counter.
REQ-017 Without ARB_STARVE_GUARD_EN, arbitration SHALL be strict data priority and no counter logic SHALL be present.

Structure
REQ-018 Package mem_arb_pkg SHALL hold the state enum (IDLE, ISSUE, RESP), the owner enum (OWN_IF, OWN_D) and the default widths.
REQ-019 Sub-module arb_pick SHALL contain the winner selection and the optional starvation counter; mem_arbiter SHALL contain the FSM and the datapath registers.

Verification
REQ-020 Single fetch: if_req=1, if_addr=0x0010, mem returns 0x00500093 -> if_gnt in cycle 1, if_valid in cycle 2 with if_rdata=0x00500093, busy=1 for 2 cycles.
REQ-021 Collision: if_req and d_req (read, d_addr=0x0200) asserted together -> d_gnt first, if_gnt 2 cycles later, no gnt overlap.
REQ-022 Write then read: d_we=1, addr 0x0040, wdata 0xDEADBEEF, then a read of 0x0040 -> mem_we=1 only in the write ISSUE cycle; the read returns 0xDEADBEEF; d_rdata unchanged by the write's d_valid.
REQ-023 Starvation with macro defined and STARVE_MAX=4: d_req held high and if_req high -> fetch granted on the 5th arbitration. Without the macro, fetch is never granted while d_req is high.
REQ-024 Reset mid-access: rst=0 during RESP -> no valid pulse, all outputs 0 immediately (asynchronously); after release, a pending if_req is granted 1 cycle later.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the fetch/data memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF     = 14;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Winner selection between fetch and data requesters. Data has priority;
// with ARB_STARVE_GUARD_EN defined, a fetch-loss counter forces a fetch win.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
`ifdef ARB_STARVE_GUARD_EN
    input  logic   clk,
    input  logic   rst,
    input  logic   arb_en,
`endif
    input  logic   if_req,
    input  logic   d_req,
    output owner_t winner
);

    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("arb_pick: STARVE_MAX must be at least 1");
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             force_if;

    assign force_if = (starve_cnt == CNT_W'(STARVE_MAX));

    always_comb begin
        winner = OWN_D;
        if (if_req && (!d_req || force_if)) begin
            winner = OWN_IF;
        end
    end

    // Counts arbitrations lost by a waiting fetch; cannot pass STARVE_MAX
    // because reaching it hands the next arbitration to fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (arb_en) begin
            if (winner == OWN_IF) begin
                starve_cnt <= '0;
            end else if (if_req) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    assign winner = (if_req && !d_req) ? OWN_IF : OWN_D;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between fetch and data ports.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
//
// state | meaning
// IDLE  | no access in flight, waiting for a request
// ISSUE | memory access driven, winner's gnt high
// RESP  | memory data returning, winner's valid high; may re-arbitrate
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t        state;
    owner_t            owner;
    owner_t            winner;
    logic              resp_we;
    logic              arb_en;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    assign arb_en = (state != ISSUE) && (if_req || d_req);

    arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
`ifdef ARB_STARVE_GUARD_EN
        .clk    (clk),
        .rst    (rst),
        .arb_en (arb_en),
`endif
        .if_req (if_req),
        .d_req  (d_req),
        .winner (winner)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            resp_we   <= 1'b0;
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            if_gnt   <= 1'b0;
            d_gnt    <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (arb_en) begin
                        state  <= ISSUE;
                        owner  <= winner;
                        busy   <= 1'b1;
                        mem_en <= 1'b1;
                        // A fetch leaves mem_wdata at its last value.
                        if (winner == OWN_D) begin
                            d_gnt     <= 1'b1;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            resp_we   <= d_we;
                        end else begin
                            if_gnt    <= 1'b1;
                            mem_addr  <= if_addr;
                            resp_we   <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ISSUE: begin
                    state <= RESP;
                    busy  <= 1'b1;
                    if (owner == OWN_D) begin
                        d_valid <= 1'b1;
                    end else begin
                        if_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else if (state == RESP) begin
            if (if_valid) begin
                if_rdata_q <= mem_rdata;
            end
            if (d_valid && !resp_we) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

    // Memory data only exists during RESP, so it is passed through on the
    // completion cycle and held from the register afterwards.
    assign if_rdata = if_valid ? mem_rdata : if_rdata_q;
    assign d_rdata  = (d_valid && !resp_we) ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int AW   = 14;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_valid;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_valid;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory seen by the DUT, and an independent copy owned by the model.
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: an access may start at any edge once the
    // previous one has had its issue and response cycles.
    int          cyc = 0;
    int          next_arb = 0;
    int          starve = 0;
    logic        pend_if = 0, pend_d = 0, pend_rd = 0;
    logic [31:0] pend_data = 0;
    logic [31:0] m_if_hold = 0, m_d_hold = 0, m_addr = 0, m_wdata = 0;

    initial begin
        logic        e_ifg, e_dg, e_ifv, e_dv, e_en, e_we, e_busy, take_if;
        logic [31:0] e_if_rd, e_d_rd;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            e_ifg = 0; e_dg = 0; e_en = 0; e_we = 0;
            if (!rst) begin
                next_arb = cyc; starve = 0;
                pend_if = 0; pend_d = 0; pend_rd = 0; pend_data = 0;
                m_if_hold = 0; m_d_hold = 0; m_addr = 0; m_wdata = 0;
                e_ifv = 0; e_dv = 0; e_if_rd = 0; e_d_rd = 0;
            end else begin
                e_ifv = pend_if;
                e_dv  = pend_d;
                if (pend_if) m_if_hold = pend_data;
                if (pend_d && pend_rd) m_d_hold = pend_data;
                e_if_rd = m_if_hold;
                e_d_rd  = m_d_hold;
                pend_if = 0; pend_d = 0;
                if (cyc >= next_arb && (if_req || d_req)) begin
                    take_if = if_req && !d_req;
`ifdef ARB_STARVE_GUARD_EN
                    if (if_req && starve >= SMAX) take_if = 1;
                    if (take_if) starve = 0;
                    else if (if_req) starve++;
`endif
                    next_arb = cyc + 2;
                    e_en = 1;
                    if (take_if) begin
                        e_ifg = 1; m_addr = 32'(if_addr);
                        pend_if = 1; pend_rd = 1; pend_data = ref_mem[if_addr];
                    end else begin
                        e_dg = 1; e_we = d_we; m_addr = 32'(d_addr); m_wdata = d_wdata;
                        pend_d = 1; pend_rd = !d_we;
                        if (d_we) ref_mem[d_addr] = d_wdata;
                        else      pend_data = ref_mem[d_addr];
                    end
                end
            end
            e_busy = e_en || e_ifv || e_dv;
            chk("m_if_gnt", if_gnt, e_ifg);
            chk("m_d_gnt", d_gnt, e_dg);
            chk("m_if_valid", if_valid, e_ifv);
            chk("m_d_valid", d_valid, e_dv);
            chk("m_mem_en", mem_en, e_en);
            chk("m_mem_we", mem_we, e_we);
            chk("m_mem_addr", mem_addr, m_addr);
            chk("m_mem_wdata", mem_wdata, m_wdata);
            chk("m_busy", busy, e_busy);
            chk("m_if_rdata", if_rdata, e_if_rd);
            chk("m_d_rdata", d_rdata, e_d_rd);
        end
    end

    initial begin
        int arb, got, ok, p;
        for (int i = 0; i < (1 << AW); i++) begin
            logic [31:0] v;
            v = $urandom;
            mem[i] = v; ref_mem[i] = v;
        end
        mem[14'h10]  = 32'h0050_0093; ref_mem[14'h10]  = 32'h0050_0093;
        mem[14'h200] = 32'h1234_5678; ref_mem[14'h200] = 32'h1234_5678;

        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1;

        // single fetch
        @(negedge clk); if_req = 1; if_addr = 14'h10;
        @(posedge clk); #1;
        chk("t1_if_gnt", if_gnt, 1); chk("t1_busy_issue", busy, 1); chk("t1_mem_addr", mem_addr, 32'h10);
        @(negedge clk) if_req = 0;
        @(posedge clk); #1;
        chk("t1_if_valid", if_valid, 1); chk("t1_if_rdata", if_rdata, 32'h0050_0093); chk("t1_busy_resp", busy, 1);
        @(posedge clk); #1;
        chk("t1_busy_idle", busy, 0); chk("t1_if_rdata_hold", if_rdata, 32'h0050_0093);

        // collision: data first, fetch two cycles later
        @(negedge clk); if_req = 1; if_addr = 14'h20; d_req = 1; d_we = 0; d_addr = 14'h200;
        @(posedge clk); #1;
        chk("t2_d_gnt_first", d_gnt, 1); chk("t2_if_gnt_held", if_gnt, 0);
        @(negedge clk) d_req = 0;
        @(posedge clk); #1;
        chk("t2_d_valid", d_valid, 1); chk("t2_d_rdata", d_rdata, 32'h1234_5678); chk("t2_if_gnt_wait", if_gnt, 0);
        @(posedge clk); #1;
        chk("t2_if_gnt_second", if_gnt, 1); chk("t2_d_gnt_off", d_gnt, 0);
        @(negedge clk) if_req = 0;
        @(posedge clk); #1;

        // write then read back
        @(negedge clk); d_req = 1; d_we = 1; d_addr = 14'h40; d_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        chk("t3_wr_gnt", d_gnt, 1); chk("t3_wr_mem_we", mem_we, 1); chk("t3_wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk) d_req = 0;
        @(posedge clk); #1;
        chk("t3_wr_valid", d_valid, 1); chk("t3_mem_we_resp", mem_we, 0); chk("t3_d_rdata_kept", d_rdata, 32'h1234_5678);
        @(negedge clk); d_req = 1; d_we = 0;
        @(posedge clk); #1;
        chk("t3_rd_gnt", d_gnt, 1); chk("t3_rd_mem_we", mem_we, 0);
        @(negedge clk) d_req = 0;
        @(posedge clk); #1;
        chk("t3_rd_valid", d_valid, 1); chk("t3_rd_data", d_rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("t3_rd_hold", d_rdata, 32'hDEAD_BEEF);

        // starvation: data requested continuously alongside a fetch
        @(negedge clk); if_req = 1; if_addr = 14'h5; d_req = 1; d_we = 0; d_addr = 14'h7;
        arb = 0; got = 0;
        for (int k = 0; k < 24 && got == 0 && arb < 10; k++) begin
            @(posedge clk); #1;
            if (d_gnt) arb++;
            if (if_gnt) got = arb + 1;
            @(negedge clk);
            if (if_gnt) if_req = 0;
            d_addr = AW'($urandom_range(0, 31));
        end
`ifdef ARB_STARVE_GUARD_EN
        chk("t4_fetch_arbitration", got, 5);
`else
        chk("t4_fetch_never_granted", got, 0);
`endif
        d_req = 0;
        if (if_req) begin
            ok = 0;
            for (int k = 0; k < 8 && ok == 0; k++) begin
                @(posedge clk); #1;
                if (if_gnt) ok = 1;
            end
            chk("t4_fetch_after_data_stops", ok, 1);
            @(negedge clk) if_req = 0;
        end
        repeat (3) @(negedge clk);

        // asynchronous reset while an access is in flight
        d_req = 1; d_we = 0; d_addr = 14'h9;
        @(posedge clk); #1;
        chk("t5_d_gnt", d_gnt, 1);
        @(negedge clk); d_req = 0; rst = 0; if_req = 1; if_addr = 14'h10;
        #1;
        chk("t5_async_d_gnt", d_gnt, 0); chk("t5_async_mem_en", mem_en, 0); chk("t5_async_busy", busy, 0);
        chk("t5_async_d_rdata", d_rdata, 0); chk("t5_async_if_rdata", if_rdata, 0); chk("t5_async_mem_addr", mem_addr, 0);
        @(posedge clk); #1;
        chk("t5_no_valid", d_valid, 0);
        @(negedge clk) rst = 1;
        @(posedge clk); #1;
        chk("t5_if_gnt_after_release", if_gnt, 1);
        @(negedge clk) if_req = 0;
        @(posedge clk); #1;
        chk("t5_if_rdata", if_rdata, 32'h0050_0093);

        // random traffic, three load levels
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            p = ((i / 500) % 3 == 0) ? 20 : (((i / 500) % 3 == 1) ? 60 : 95);
            if (if_gnt) if_req = 0;
            if (d_gnt)  d_req = 0;
            if (!if_req && $urandom_range(0, 99) < p) begin
                if_req = 1; if_addr = AW'($urandom_range(0, 31));
            end
            if (!d_req && $urandom_range(0, 99) < p) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1));
                d_addr = AW'($urandom_range(0, 31)); d_wdata = $urandom;
            end
        end
        @(negedge clk); if_req = 0; d_req = 0;
        repeat (4) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
